// File: rtl/clic_preempt_sched_pkg.sv
// Shared configuration for the CLIC preemption scheduler: sizes, derived widths, types, FSM encoding.
package clic_preempt_sched_pkg;

  localparam int VecSize        = 8;
  localparam int PrioNum        = 4;
  localparam int StackDepth     = 4;
  localparam int TimeStampWidth = 8;

  localparam int VecW   = $clog2(VecSize);
  localparam int PrioW  = $clog2(PrioNum);
  localparam int DepthW = $clog2(StackDepth + 1);
  localparam int SlotW  = $clog2(StackDepth);

  typedef logic [VecW-1:0]           vec_t;
  typedef logic [PrioW-1:0]          prio_t;
  typedef logic [DepthW-1:0]         depth_t;
  typedef logic [SlotW-1:0]          slot_t;
  typedef logic [TimeStampWidth-1:0] timestamp_t;

  localparam depth_t DepthFull = depth_t'(StackDepth);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_SETTLE = 2'd2
  } sched_state_e;

  function automatic prio_t prio_max(input prio_t a, input prio_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clic_preempt_sched_stack.sv
// Preemption stack of active handler priorities; a pop and a push in one cycle apply pop first.
module clic_prio_stack
  import clic_preempt_sched_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push_i,
  input  prio_t  push_prio_i,
  input  logic   pop_i,
  output prio_t  top_o,
  output depth_t depth_o,
  output logic   full_o,
  output logic   empty_o,
  output logic   can_push_o,
  output logic   pop_err_o
);

  prio_t  entry_q [StackDepth];
  prio_t  entry_d [StackDepth];
  depth_t depth_q, depth_d;
  depth_t depth_pop;
  logic   pop_ok;
  logic   push_ok;
  slot_t  top_slot;

  always_comb begin
    empty_o    = (depth_q == '0);
    full_o     = (depth_q == DepthFull);
    pop_ok     = pop_i & ~empty_o;
    pop_err_o  = pop_i & empty_o;
    depth_pop  = depth_q - depth_t'(pop_ok);
    // Room is judged after the same-cycle pop, so it never depends on push_i itself.
    can_push_o = (depth_pop != DepthFull);
    push_ok    = push_i & can_push_o;
    depth_d    = depth_pop + depth_t'(push_ok);
    entry_d    = entry_q;
    if (push_ok) begin
      entry_d[slot_t'(depth_pop)] = push_prio_i;
    end
    top_slot = slot_t'(depth_q - depth_t'(1));
    top_o    = empty_o ? '0 : entry_q[top_slot];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q <= '0;
      for (int i = 0; i < StackDepth; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      depth_q <= depth_d;
      entry_q <= entry_d;
    end
  end

  assign depth_o = depth_q;

endmodule

// File: rtl/clic_preempt_sched.sv
// CLIC interrupt scheduler: winner select, req/ack handshake FSM and nested-preemption tracking.
// Optional CLIC_LATENCY_STAMP_EN adds per-vector pend-to-ack latency stamps on lat_o.
module clic_preempt_sched
  import clic_preempt_sched_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [VecSize-1:0]         pend_i,
  input  logic [VecSize-1:0]         en_i,
  input  logic [VecSize*PrioW-1:0]   prio_i,
  input  logic [PrioW-1:0]           thresh_i,
  input  logic                       mie_i,
  output logic                       irq_req_o,
  output logic [VecW-1:0]            irq_vec_o,
  input  logic                       irq_ack_i,
  input  logic                       irq_ret_i,
  output logic [VecSize-1:0]         clear_o,
  output logic [PrioW-1:0]           cur_prio_o,
  output logic [DepthW-1:0]          depth_o,
  output logic                       err_o
`ifdef CLIC_LATENCY_STAMP_EN
  ,
  output logic [VecSize*TimeStampWidth-1:0] lat_o
`endif
);

  sched_state_e state_q, state_d;
  vec_t         vec_q, vec_d;
  logic [VecSize-1:0] clear_q, clear_d;
  logic         err_q, err_d;

  prio_t        prio_v [VecSize];
  logic [VecSize-1:0] cand;
  prio_t        eff_thresh;
  logic         win_any;
  vec_t         win_vec;
  prio_t        win_prio;

  prio_t        stack_top;
  depth_t       stack_depth;
  logic         stack_full;
  logic         stack_empty;
  logic         stack_can_push;
  logic         stack_pop_err;
  logic         in_req;
  logic         ack_take;
  logic         ack_err;

  assign eff_thresh = prio_max(thresh_i, stack_top);

  generate
    for (genvar gi = 0; gi < VecSize; gi++) begin : g_cand
      assign prio_v[gi] = prio_i[gi*PrioW +: PrioW];
      assign cand[gi]   = pend_i[gi] & en_i[gi] & (prio_v[gi] > eff_thresh);
    end
  endgenerate

  // Strict '>' on ascending index keeps the lowest index on a priority tie.
  always_comb begin
    win_any  = 1'b0;
    win_vec  = '0;
    win_prio = '0;
    for (int i = 0; i < VecSize; i++) begin
      if (cand[i] && (!win_any || prio_v[i] > win_prio)) begin
        win_any  = 1'b1;
        win_vec  = vec_t'(i);
        win_prio = prio_v[i];
      end
    end
  end

  assign in_req   = (state_q == ST_REQ);
  assign ack_take = in_req & irq_ack_i & stack_can_push;
  assign ack_err  = in_req & irq_ack_i & ~stack_can_push;

  clic_prio_stack u_stack (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (ack_take),
    .push_prio_i (prio_v[vec_q]),
    .pop_i       (irq_ret_i),
    .top_o       (stack_top),
    .depth_o     (stack_depth),
    .full_o      (stack_full),
    .empty_o     (stack_empty),
    .can_push_o  (stack_can_push),
    .pop_err_o   (stack_pop_err)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    clear_d = '0;
    err_d   = err_q | ack_err | stack_pop_err;
    unique case (state_q)
      ST_IDLE: begin
        if (mie_i && win_any && !stack_full) begin
          state_d = ST_REQ;
          vec_d   = win_vec;
        end
      end
      ST_REQ: begin
        if (irq_ack_i) begin
          if (ack_take) begin
            clear_d[vec_q] = 1'b1;
            state_d        = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!(mie_i && win_any)) begin
          state_d = ST_IDLE;
        end else if (!cand[vec_q] || (win_prio > prio_v[vec_q])) begin
          vec_d = win_vec;
        end
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      clear_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      clear_q <= clear_d;
      err_q   <= err_d;
    end
  end

  assign irq_req_o  = in_req;
  assign irq_vec_o  = vec_q;
  assign clear_o    = clear_q;
  assign cur_prio_o = stack_top;
  assign depth_o    = stack_depth;
  assign err_o      = err_q;

`ifdef CLIC_LATENCY_STAMP_EN
  logic [VecSize-1:0] pend_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_prev_q <= '0;
    end else begin
      pend_prev_q <= pend_i;
    end
  end

  generate
    for (genvar gi = 0; gi < VecSize; gi++) begin : g_lat
      timestamp_t cnt_q, cnt_d;
      timestamp_t lat_q, lat_d;
      logic       run_q, run_d;
      logic       take;

      assign take = ack_take & (vec_q == vec_t'(gi));

      // The rising-edge cycle counts as 1 so an ack N cycles later stamps N.
      always_comb begin
        cnt_d = cnt_q;
        lat_d = lat_q;
        run_d = run_q;
        if (take) begin
          lat_d = cnt_q;
          cnt_d = '0;
          run_d = 1'b0;
        end else if (pend_i[gi] && !pend_prev_q[gi]) begin
          cnt_d = timestamp_t'(1);
          run_d = 1'b1;
        end else if (run_q && (cnt_q != '1)) begin
          cnt_d = cnt_q + timestamp_t'(1);
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
          lat_q <= '0;
          run_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          lat_q <= lat_d;
          run_q <= run_d;
        end
      end

      assign lat_o[gi*TimeStampWidth +: TimeStampWidth] = lat_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_clic_preempt_sched.sv
// Directed self-checking bench for clic_preempt_sched (latency stamps checked when CLIC_LATENCY_STAMP_EN is set).
module tb_clic_preempt_sched;
  import clic_preempt_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  pend;
  logic [7:0]  en;
  logic [15:0] prio_bus;
  logic [1:0]  thresh;
  logic        mie;
  logic        ack;
  logic        ret;
  logic        irq_req;
  logic [2:0]  irq_vec;
  logic [7:0]  clear;
  logic [1:0]  cur_prio;
  logic [2:0]  depth;
  logic        err;
`ifdef CLIC_LATENCY_STAMP_EN
  logic [63:0] lat;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clic_preempt_sched dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pend_i     (pend),
    .en_i       (en),
    .prio_i     (prio_bus),
    .thresh_i   (thresh),
    .mie_i      (mie),
    .irq_req_o  (irq_req),
    .irq_vec_o  (irq_vec),
    .irq_ack_i  (ack),
    .irq_ret_i  (ret),
    .clear_o    (clear),
    .cur_prio_o (cur_prio),
    .depth_o    (depth),
    .err_o      (err)
`ifdef CLIC_LATENCY_STAMP_EN
    ,
    .lat_o      (lat)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("chk  %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int v, input int p);
    logic [1:0] p2;
    p2 = p[1:0];
    prio_bus[v*2 +: 2] = p2;
  endtask

  initial begin
    reset_n = 1'b0; pend = '0; en = 8'hFF; prio_bus = '0;
    thresh = '0; mie = 1'b0; ack = 1'b0; ret = 1'b0;
    tick(); tick();
    check("rst_req",   32'(irq_req), 0);
    check("rst_vec",   32'(irq_vec), 0);
    check("rst_clear", 32'(clear), 0);
    check("rst_cur",   32'(cur_prio), 0);
    check("rst_depth", 32'(depth), 0);
    check("rst_err",   32'(err), 0);
    reset_n = 1'b1; mie = 1'b1;
    tick();

    // 1: single vector request and ack
    set_prio(3, 2); pend = 8'h08;
    tick();
    check("t1_req", 32'(irq_req), 1);
    check("t1_vec", 32'(irq_vec), 3);
    ack = 1'b1; tick(); ack = 1'b0; pend[3] = 1'b0;
    check("t1_clear", 32'(clear), 32'h08);
    check("t1_depth", 32'(depth), 1);
    check("t1_cur",   32'(cur_prio), 2);
    check("t1_settle_req", 32'(irq_req), 0);
    tick();
    check("t1_clear_once", 32'(clear), 0);

    // 2: low priority blocked by running handler, tie-break, drops
    set_prio(6, 1); pend = 8'h40;
    tick(); tick();
    check("t2_lowprio_blocked", 32'(irq_req), 0);
    ret = 1'b1; tick(); ret = 1'b0;
    check("t2_ret_depth", 32'(depth), 0);
    check("t2_ret_cur",   32'(cur_prio), 0);
    tick();
    check("t2_resume_req", 32'(irq_req), 1);
    check("t2_resume_vec", 32'(irq_vec), 6);
    pend = '0; tick();
    check("t2_vanish_req", 32'(irq_req), 0);
    set_prio(1, 3); set_prio(5, 3); pend = 8'h22;
    tick();
    check("t2_tie_req", 32'(irq_req), 1);
    check("t2_tie_vec", 32'(irq_vec), 1);
    mie = 1'b0; tick();
    check("t2_mie_drop", 32'(irq_req), 0);
    mie = 1'b1; pend = '0; tick();
    set_prio(2, 1); thresh = 2'd1; pend = 8'h04;
    tick(); tick();
    check("t2_thresh_block", 32'(irq_req), 0);
    thresh = 2'd0; tick();
    check("t2_thresh_open_req", 32'(irq_req), 1);
    check("t2_thresh_open_vec", 32'(irq_vec), 2);

    // 3: higher priority arrives during REQ
    set_prio(4, 3); pend = pend | 8'h10;
    tick();
    check("t3_upgrade_req", 32'(irq_req), 1);
    check("t3_upgrade_vec", 32'(irq_vec), 4);
    ack = 1'b1; tick(); ack = 1'b0; pend[4] = 1'b0;
    check("t3_clear", 32'(clear), 32'h10);
    check("t3_cur",   32'(cur_prio), 3);
    check("t3_depth", 32'(depth), 1);
    tick(); tick();
    check("t3_blocked", 32'(irq_req), 0);
    ret = 1'b1; tick(); ret = 1'b0;
    check("t3_ret_depth", 32'(depth), 0);
    tick();
    check("t3_resume_vec", 32'(irq_vec), 2);
    check("t3_resume_req", 32'(irq_req), 1);
    ack = 1'b1; tick(); ack = 1'b0; pend[2] = 1'b0;
    tick();
    ret = 1'b1; tick(); ret = 1'b0;

    // 4: fill the stack (priority rewritten at ack so each push is 1), full blocks requests
    for (int k = 0; k < 4; k++) begin
      set_prio(k, 2); pend[k] = 1'b1;
      tick();
      check("t4_fill_vec", 32'(irq_vec), 32'(k));
      ack = 1'b1; set_prio(k, 1);
      tick();
      ack = 1'b0; pend[k] = 1'b0;
      tick();
    end
    check("t4_full_depth", 32'(depth), 4);
    check("t4_full_cur",   32'(cur_prio), 1);
    set_prio(7, 3); pend[7] = 1'b1;
    tick(); tick(); tick();
    check("t4_full_no_req", 32'(irq_req), 0);
    ret = 1'b1; tick(); ret = 1'b0;
    check("t4_ret_depth", 32'(depth), 3);
    tick();
    check("t4_resume_req", 32'(irq_req), 1);
    check("t4_resume_vec", 32'(irq_vec), 7);
    ack = 1'b1; tick(); ack = 1'b0; pend[7] = 1'b0;
    check("t4_refill_depth", 32'(depth), 4);
    check("t4_refill_cur",   32'(cur_prio), 3);
    tick();
    ret = 1'b1;
    repeat (4) tick();
    ret = 1'b0;
    check("t4_empty_depth", 32'(depth), 0);
    check("t4_err_clean",   32'(err), 0);
    ret = 1'b1; tick(); ret = 1'b0;
    check("t4_ret_empty_err", 32'(err), 1);
    check("t4_ret_empty_depth", 32'(depth), 0);

    // 5: simultaneous ack and ret, then reset in REQ
    pend = 8'h04; tick();
    ack = 1'b1; tick(); ack = 1'b0; pend = '0;
    tick();
    check("t5_base_depth", 32'(depth), 1);
    check("t5_base_cur",   32'(cur_prio), 1);
    pend = 8'h20; tick();
    check("t5_req_vec", 32'(irq_vec), 5);
    ack = 1'b1; ret = 1'b1; tick(); ack = 1'b0; ret = 1'b0; pend = '0;
    check("t5_ackret_depth", 32'(depth), 1);
    check("t5_ackret_cur",   32'(cur_prio), 3);
    tick();
    ret = 1'b1; tick(); ret = 1'b0;
    pend = 8'h20; tick();
    check("t5_prereset_req", 32'(irq_req), 1);
    reset_n = 1'b0;
    #1;
    check("t5_reset_req",   32'(irq_req), 0);
    check("t5_reset_depth", 32'(depth), 0);
    check("t5_reset_err",   32'(err), 0);
    pend = '0; tick();
    reset_n = 1'b1; tick();

`ifdef CLIC_LATENCY_STAMP_EN
    // 6: latency stamps
    set_prio(0, 1); pend = 8'h01;
    repeat (5) tick();
    check("t6_req_before_ack", 32'(irq_req), 1);
    ack = 1'b1; tick(); ack = 1'b0; pend = '0;
    check("t6_lat5", 32'(lat[7:0]), 5);
    tick();
    ret = 1'b1; tick(); ret = 1'b0;
    pend = 8'h01;
    repeat (300) tick();
    ack = 1'b1; tick(); ack = 1'b0; pend = '0;
    check("t6_lat_sat", 32'(lat[7:0]), 32'hFF);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
